// File: rtl/fp96_cmp_result_queue_if.sv
// Condition-interface bundle between the FP96 compare stage and the result queue.
// master drives compare results and consumes the head; slave is the queue.
interface fp96_cmp_result_queue_if #(
  parameter int TAGW = 6
);
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     cmp_o;
  logic            cmp_nan;
  logic            cmp_snan;
  logic            cmp_inf;
  logic [3:0]      cond;
  logic            sig;
  logic [TAGW-1:0] tag;
  logic            out_valid;
  logic            out_ready;
  logic            out_bit;
  logic            out_nv;
  logic [TAGW-1:0] out_tag;

  modport master (
    output in_valid, cmp_o, cmp_nan, cmp_snan, cmp_inf,
    output cond, sig, tag, out_ready,
    input  in_ready, out_valid, out_bit, out_nv, out_tag
  );

  modport slave (
    input  in_valid, cmp_o, cmp_nan, cmp_snan, cmp_inf,
    input  cond, sig, tag, out_ready,
    output in_ready, out_valid, out_bit, out_nv, out_tag
  );
endinterface

// File: rtl/fp96_cmp_result_queue.sv
// FP96 compare result queue: selects condition bit, flags invalid, queues {bit,nv,tag}.
// Define FPCMP_TRAP_EN to add trap_en/trap (invalid trap that stalls intake).
module fp96_cmp_result_queue #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  fp96_cmp_result_queue_if.slave   bus,
  input  logic                     clr_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     flag_nv,
  output logic                     flag_inf
`ifdef FPCMP_TRAP_EN
  ,
  input  logic                     trap_en,
  output logic                     trap
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TAGW+1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [CW-1:0]   r_count;
  logic            r_flag_nv;
  logic            r_flag_inf;

  logic w_rsv;
  logic w_bit;
  logic w_nv;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_unused;

  // cond[2:0] of 5..7 selects the reserved gaps in both mask halves
  assign w_rsv  = bus.cond[2:0] > 3'd4;
  assign w_bit  = !w_rsv & bus.cmp_o[bus.cond];
  assign w_nv   = !w_rsv &
                  (bus.cmp_snan | (bus.sig & bus.cmp_o[4]));
  assign w_full = r_count == CW'(DEPTH);

`ifdef FPCMP_TRAP_EN
  logic r_trap;
  assign bus.in_ready = !w_full & !rst & !r_trap;
  assign trap         = r_trap;
`else
  assign bus.in_ready = !w_full & !rst;
`endif

  assign bus.out_valid = r_count != '0;
  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  assign {bus.out_bit, bus.out_nv, bus.out_tag} = r_mem[r_rp];
  assign count    = r_count;
  assign flag_nv  = r_flag_nv;
  assign flag_inf = r_flag_inf;
  assign w_unused = bus.cmp_nan;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= {w_bit, w_nv, bus.tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_flag_nv  <= 1'b0;
      r_flag_inf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      // a setting push beats a same-cycle clear
      if (w_push && w_nv) begin
        r_flag_nv <= 1'b1;
      end else if (clr_flags) begin
        r_flag_nv <= 1'b0;
      end
      if (w_push && bus.cmp_inf) begin
        r_flag_inf <= 1'b1;
      end else if (clr_flags) begin
        r_flag_inf <= 1'b0;
      end
    end
  end

`ifdef FPCMP_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trap <= 1'b0;
    end else if (w_push && w_nv && trap_en) begin
      r_trap <= 1'b1;
    end else if (clr_flags) begin
      r_trap <= 1'b0;
    end
  end
`endif
endmodule
